// File: rtl/reg_op_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_op_pkg
//  Description : Shared widths, opcode and FSM state encodings for the
//                register-operation sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_op_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    OP_MOV = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_INC = 3'd3,
    OP_CMP = 3'd4,
    OP_SUM = 3'd5,
    OP_MAX = 3'd6,
    OP_INV = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_CAP_A = 3'd2,
    S_RD_B  = 3'd3,
    S_CAP_B = 3'd4,
    S_EXEC  = 3'd5,
    S_WR    = 3'd6,
    S_DONE  = 3'd7
  } state_e;

  // Ops that fetch a second operand from src_b.
  function automatic logic op_needs_b(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

  // Ops that loop over a register range.
  function automatic logic op_is_range(input op_e op);
    return (op == OP_SUM) || (op == OP_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_op_sequencer_if
//  Description : Command handshake, register-file bus and status signals of
//                the register-operation sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface reg_op_sequencer_if #(
  parameter int DATA_W = reg_op_pkg::DATA_W,
  parameter int ADDR_W = reg_op_pkg::ADDR_W
);
  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_src_a;
  logic [ADDR_W-1:0] cmd_src_b;
  logic [ADDR_W-1:0] cmd_dst;
  logic [3:0]        cmd_count;
  // register-file master port
  logic [ADDR_W-1:0] rf_address;
  logic              rf_read_en;
  logic              rf_write_en;
  logic [DATA_W-1:0] rf_data_in;
  logic [DATA_W-1:0] rf_data_out;
  // status
  logic              busy;
  logic              done;
  logic              err;
  logic              flag_carry;
  logic              flag_zero;
  logic              flag_ge;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_count, rf_data_out,
    output cmd_ready, rf_address, rf_read_en, rf_write_en, rf_data_in,
    output busy, done, err, flag_carry, flag_zero, flag_ge
  );

  // Command issuer / register-file side.
  modport master (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_count, rf_data_out,
    input  cmd_ready, rf_address, rf_read_en, rf_write_en, rf_data_in,
    input  busy, done, err, flag_carry, flag_zero, flag_ge
  );

endinterface
`default_nettype wire

// File: rtl/alu8.sv
`default_nettype none
// ============================================================================
//  Module      : alu8
//  Description : Combinational ALU for the sequencer: add, subtract,
//                increment, compare and unsigned max, with carry/zero/ge.
//  Revision    : 1.0  initial release
// ============================================================================
module alu8
  import reg_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_ge
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic [WIDTH:0] w_inc;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_inc  = {1'b0, i_a} + (WIDTH + 1)'(1);

  // a >= b exactly when the subtraction does not borrow
  assign o_ge = ~w_diff[WIDTH];

  // Result and carry/borrow select; SUM reuses the adder, MAX the comparator.
  always_comb begin
    o_y     = i_a;
    o_carry = 1'b0;
    case (i_op)
      OP_ADD, OP_SUM: {o_carry, o_y} = w_sum;
      OP_SUB, OP_CMP: {o_carry, o_y} = w_diff;
      OP_INC:         {o_carry, o_y} = w_inc;
      OP_MAX:         o_y = o_ge ? i_a : i_b;
      default:        o_y = i_a;
    endcase
  end

  // For CMP the difference is zero exactly when a == b.
  assign o_zero = (o_y == '0);

endmodule
`default_nettype wire

// File: rtl/reg_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_op_sequencer
//  Description : Accepts one register operation at a time, fetches operands
//                from an external register file, executes on alu8 and writes
//                the result back, updating carry/zero/ge flags.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_op_sequencer
  import reg_op_pkg::*;
#(
  parameter int DATA_W = reg_op_pkg::DATA_W,
  parameter int ADDR_W = reg_op_pkg::ADDR_W
) (
  input  wire logic         clk,
  input  wire logic         rst,
  reg_op_sequencer_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  op_e               r_op;
  op_e               w_cmd_op;
  logic [ADDR_W-1:0] r_src_a;
  logic [ADDR_W-1:0] r_src_b;
  logic [ADDR_W-1:0] r_dst;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;
  logic              r_err;
  logic              r_sum_c;
  logic              r_carry;
  logic              r_zero;
  logic              r_ge;

  logic              w_bad_cmd;
  logic              w_last;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_y;
  logic              w_alu_c;
  logic              w_alu_z;
  logic              w_alu_ge;

  assign w_cmd_op = op_e'(bus.cmd_op);
  // Invalid opcode, or an empty range, completes at once with err.
  // An empty count only matters for the range ops.
  assign w_bad_cmd = (w_cmd_op == OP_INV) ||
                     (op_is_range(w_cmd_op) && (bus.cmd_count == '0));
  assign w_last    = (r_idx == (r_count - CNT_W'(1)));

  // Range ops combine the fetched element with the running accumulator.
  assign w_alu_b = op_is_range(r_op) ? r_res : r_b;

  alu8 #(.WIDTH(DATA_W)) u_alu (
    .i_op    (r_op),
    .i_a     (r_a),
    .i_b     (w_alu_b),
    .o_y     (w_alu_y),
    .o_carry (w_alu_c),
    .o_zero  (w_alu_z),
    .o_ge    (w_alu_ge)
  );

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.cmd_valid) w_state_nxt = w_bad_cmd ? S_DONE : S_RD_A;
      S_RD_A:  w_state_nxt = S_CAP_A;
      S_CAP_A: w_state_nxt = op_needs_b(r_op) ? S_RD_B : S_EXEC;
      S_RD_B:  w_state_nxt = S_CAP_B;
      S_CAP_B: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (r_op == OP_CMP)                      w_state_nxt = S_DONE;
        else if (op_is_range(r_op) && !w_last)   w_state_nxt = S_RD_A;
        else                                     w_state_nxt = S_WR;
      end
      S_WR:    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register-file address: operand in read states, destination on write.
  always_comb begin
    bus.rf_address = '0;
    case (r_state)
      S_RD_A:  bus.rf_address = r_src_a + ADDR_W'(r_idx);
      S_RD_B:  bus.rf_address = r_src_b;
      S_WR:    bus.rf_address = r_dst;
      default: bus.rf_address = '0;
    endcase
  end

  assign bus.cmd_ready   = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.rf_read_en  = (r_state == S_RD_A) || (r_state == S_RD_B);
  assign bus.rf_write_en = (r_state == S_WR);
  assign bus.rf_data_in  = (r_state == S_WR) ? r_res : '0;
  assign bus.done        = (r_state == S_DONE);
  assign bus.err         = (r_state == S_DONE) && r_err;
  assign bus.flag_carry  = r_carry;
  assign bus.flag_zero   = r_zero;
  assign bus.flag_ge     = r_ge;

  // Command latch, operand capture, accumulation and flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= OP_MOV;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_sum_c <= 1'b0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_ge    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_op    <= w_cmd_op;
            r_src_a <= bus.cmd_src_a;
            r_src_b <= bus.cmd_src_b;
            r_dst   <= bus.cmd_dst;
            r_count <= bus.cmd_count;
            r_idx   <= '0;
            r_res   <= '0;
            r_sum_c <= 1'b0;
            r_err   <= w_bad_cmd;
          end
        end
        S_CAP_A: r_a <= bus.rf_data_out;
        S_CAP_B: r_b <= bus.rf_data_out;
        S_EXEC: begin
          case (r_op)
            OP_MOV: begin
              r_res  <= w_alu_y;
              r_zero <= w_alu_z;
            end
            OP_ADD, OP_SUB, OP_INC: begin
              r_res   <= w_alu_y;
              r_carry <= w_alu_c;
              r_zero  <= w_alu_z;
            end
            OP_CMP: begin
              r_ge   <= w_alu_ge;
              r_zero <= w_alu_z;
            end
            OP_SUM: begin
              // carry is sticky across the whole range, published on the last element
              r_res   <= w_alu_y;
              r_sum_c <= r_sum_c | w_alu_c;
              r_idx   <= r_idx + CNT_W'(1);
              if (w_last) begin
                r_carry <= r_sum_c | w_alu_c;
                r_zero  <= w_alu_z;
              end
            end
            OP_MAX: begin
              r_res <= w_alu_y;
              r_idx <= r_idx + CNT_W'(1);
              if (w_last) r_zero <= w_alu_z;
            end
            default: r_res <= r_res;
          endcase
        end
        default: r_res <= r_res;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_op_sequencer
//  Description : Directed, table-driven bench for reg_op_sequencer with a
//                behavioural 32-entry register file.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_op_sequencer;

  typedef struct {
    logic [2:0] op;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] dst;
    logic [3:0] cnt;
    int         cyc;     // cycle after handshake in which done is high
    int         rd;      // expected rf_read_en pulses
    int         wr;      // expected rf_write_en pulses
    logic [7:0] val;     // expected register content at dst afterwards
    logic       err;
    logic [2:0] czg;     // {carry, zero, ge} after the command
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_op_sequencer_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  reg_op_sequencer #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [32];
  logic       poke_en   = 1'b0;
  logic [4:0] poke_addr = '0;
  logic [7:0] poke_data = '0;
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         overlap   = 0;
  vec_t       vecs [16];

  // Register file: synchronous read (data the cycle after read_en), synchronous write.
  always @(posedge clk) begin
    if (poke_en)              mem[poke_addr] <= poke_data;
    else if (bus.rf_write_en) mem[bus.rf_address] <= bus.rf_data_in;
    if (bus.rf_read_en)       bus.rf_data_out <= mem[bus.rf_address];
  end

  // Read and write strobes must never coincide.
  always @(negedge clk) if (bus.rf_read_en && bus.rf_write_en) overlap++;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic poke(input logic [4:0] addr, input logic [7:0] data);
    poke_en = 1'b1; poke_addr = addr; poke_data = data;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [3:0] cnt);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_src_a = a;
    bus.cmd_src_b = b; bus.cmd_dst = d; bus.cmd_count = cnt;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Issue a command, then watch up to 40 cycles for done, counting bus strobes.
  task automatic run_cmd(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [3:0] cnt,
                         output int cyc, output int rd, output int wr, output logic e);
    issue(op, a, b, d, cnt);
    cyc = 0; rd = 0; wr = 0; e = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.rf_read_en)  rd++;
      if (bus.rf_write_en) wr++;
      if (bus.done) begin
        cyc = n; e = bus.err;
        break;
      end
    end
  endtask

  initial begin
    int   cyc, rd, wr, wr_seen;
    logic e;

    //            op    a      b      dst    cnt   cyc rd wr val    err czg
    vecs[0]  = '{3'd1, 5'd4,  5'd6,  5'd10, 4'd1,  7, 2, 1, 8'd93,  1'b0, 3'b100}; // ADD
    vecs[1]  = '{3'd2, 5'd6,  5'd8,  5'd11, 4'd1,  7, 2, 1, 8'd176, 1'b0, 3'b000}; // SUB
    vecs[2]  = '{3'd2, 5'd8,  5'd4,  5'd12, 4'd1,  7, 2, 1, 8'd147, 1'b0, 3'b100}; // SUB borrow
    vecs[3]  = '{3'd4, 5'd6,  5'd4,  5'd25, 4'd1,  6, 2, 0, 8'd0,   1'b0, 3'b101}; // CMP ge
    vecs[4]  = '{3'd3, 5'd12, 5'd0,  5'd12, 4'd1,  5, 1, 1, 8'd148, 1'b0, 3'b001}; // INC
    vecs[5]  = '{3'd4, 5'd4,  5'd6,  5'd25, 4'd1,  6, 2, 0, 8'd0,   1'b0, 3'b000}; // CMP lt
    vecs[6]  = '{3'd4, 5'd4,  5'd5,  5'd25, 4'd1,  6, 2, 0, 8'd0,   1'b0, 3'b011}; // CMP eq
    vecs[7]  = '{3'd2, 5'd4,  5'd4,  5'd13, 4'd1,  7, 2, 1, 8'd0,   1'b0, 3'b011}; // SUB zero
    vecs[8]  = '{3'd3, 5'd20, 5'd0,  5'd21, 4'd1,  5, 1, 1, 8'd0,   1'b0, 3'b111}; // INC 255
    vecs[9]  = '{3'd0, 5'd6,  5'd0,  5'd14, 4'd1,  5, 1, 1, 8'd208, 1'b0, 3'b101}; // MOV
    vecs[10] = '{3'd5, 5'd4,  5'd0,  5'd13, 4'd6, 20, 6, 1, 8'd250, 1'b0, 3'b101}; // SUM
    vecs[11] = '{3'd5, 5'd8,  5'd0,  5'd15, 4'd2,  8, 2, 1, 8'd64,  1'b0, 3'b001}; // SUM no carry
    vecs[12] = '{3'd6, 5'd4,  5'd0,  5'd13, 4'd6, 20, 6, 1, 8'd208, 1'b0, 3'b001}; // MAX
    vecs[13] = '{3'd6, 5'd30, 5'd0,  5'd16, 4'd4, 14, 4, 1, 8'd77,  1'b0, 3'b001}; // MAX wrap
    vecs[14] = '{3'd7, 5'd4,  5'd6,  5'd22, 4'd1,  1, 0, 0, 8'd0,   1'b1, 3'b001}; // invalid op
    vecs[15] = '{3'd5, 5'd4,  5'd0,  5'd23, 4'd0,  1, 0, 0, 8'd0,   1'b1, 3'b001}; // empty SUM

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_src_a = '0;
    bus.cmd_src_b = '0; bus.cmd_dst = '0; bus.cmd_count = '0;

    // Clear and preload the register file while reset is held.
    for (int i = 0; i < 32; i++) poke(5'(i), 8'd0);
    poke(5'd4, 8'd141); poke(5'd5, 8'd141); poke(5'd6, 8'd208); poke(5'd7, 8'd208);
    poke(5'd8, 8'd32);  poke(5'd9, 8'd32);  poke(5'd20, 8'd255);
    poke(5'd31, 8'd77); poke(5'd0, 8'd5);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 0, bus.cmd_ready, 1);
    check("rst_busy_done_err", 0, {bus.busy, bus.done, bus.err}, 0);
    check("rst_rf_strobes", 0, {bus.rf_read_en, bus.rf_write_en}, 0);
    check("rst_rf_addr_data", 0, {bus.rf_address, bus.rf_data_in}, 0);
    check("rst_flags", 0, {bus.flag_carry, bus.flag_zero, bus.flag_ge}, 0);

    for (int i = 0; i < 16; i++) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst, vecs[i].cnt, cyc, rd, wr, e);
      check("done_cycle", i, cyc, vecs[i].cyc);
      check("err", i, e, vecs[i].err);
      check("reads", i, rd, vecs[i].rd);
      check("writes", i, wr, vecs[i].wr);
      check("dst_value", i, mem[vecs[i].dst], vecs[i].val);
      check("flags_czg", i, {bus.flag_carry, bus.flag_zero, bus.flag_ge}, vecs[i].czg);
      @(negedge clk);
      check("done_err_pulse", i, {bus.done, bus.err}, 0);
    end

    // cmd_valid held while busy (with a different command) must be ignored.
    issue(3'd1, 5'd8, 5'd9, 5'd18, 4'd1);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd7; bus.cmd_dst = 5'd19;
    cyc = 0; e = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 3) bus.cmd_valid = 1'b0;
      if (n == 1) check("busy_ignores_ready", 16, bus.cmd_ready, 0);
      if (bus.done) begin
        cyc = n; e = bus.err;
        break;
      end
    end
    check("busy_ignore_cycle", 16, cyc, 7);
    check("busy_ignore_err", 16, e, 0);
    check("busy_ignore_value", 16, mem[18], 64);
    check("busy_ignore_other", 16, mem[19], 0);

    // Reset asserted in CAP_B of an ADD: aborted, nothing written.
    issue(3'd1, 5'd4, 5'd6, 5'd17, 4'd1);
    repeat (3) @(negedge clk);
    check("rdb_strobe_addr", 17, {bus.rf_read_en, bus.rf_address}, {1'b1, 5'd6});
    @(negedge clk);
    check("capb_busy", 17, bus.busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy_done_err", 17, {bus.busy, bus.done, bus.err}, 0);
    check("midrst_rf", 17, {bus.rf_read_en, bus.rf_write_en, bus.rf_address, bus.rf_data_in}, 0);
    check("midrst_flags", 17, {bus.flag_carry, bus.flag_zero, bus.flag_ge}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rf_write_en) wr_seen++;
    end
    check("abort_no_write", 17, wr_seen, 0);
    check("abort_dst_kept", 17, mem[17], 0);
    check("abort_ready", 17, bus.cmd_ready, 1);

    // The next command after the abort runs normally.
    run_cmd(3'd1, 5'd4, 5'd6, 5'd17, 4'd1, cyc, rd, wr, e);
    check("post_rst_cycle", 18, cyc, 7);
    check("post_rst_value", 18, mem[17], 93);
    check("post_rst_flags", 18, {bus.flag_carry, bus.flag_zero, bus.flag_ge}, 3'b100);

    check("rd_wr_overlap", 19, overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 Parameters: DATA_W, 8, register data width; ADDR_W, 5, register address width.
REQ-002 One clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  async active-high reset.
REQ-005 cmd_valid  in  1  command request; cmd_ready  out  1  high only in IDLE; handshake = both high at a rising edge.
REQ-006 cmd_op  in  3  0 MOV, 1 ADD, 2 SUB, 3 INC, 4 CMP, 5 SUM, 6 MAX, 7 invalid.
REQ-007 cmd_src_a, cmd_src_b, cmd_dst  in  ADDR_W each  operand/destination register; cmd_count  in  4  range length for SUM/MAX.
REQ-008 rf_address  out  ADDR_W; rf_read_en  out  1; rf_write_en  out  1; rf_data_in  out  DATA_W  register-file master port.
REQ-009 rf_data_out  in  DATA_W  register-file read data, valid the cycle after rf_read_en.
REQ-010 busy, done, err  out  1 each; flag_carry, flag_zero, flag_ge  out  1 each.

Function
REQ-011 FSM states: IDLE, RD_A, CAP_A, RD_B, CAP_B, EXEC, WR, DONE; command fields latched at handshake.
REQ-012 Two-operand ops (ADD, SUB): IDLE->RD_A->CAP_A->RD_B->CAP_B->EXEC->WR->DONE->IDLE; done high in 7th cycle after handshake.
REQ-013 MOV, INC skip RD_B/CAP_B (done 5th cycle); CMP skips WR (done 6th cycle).
REQ-014 rf_read_en/rf_write_en single-cycle pulses, never simultaneously high; rf_address = operand address in RD states, cmd_dst in WR, 0 otherwise.
REQ-015 ADD: dst=(A+B) mod 256, carry=carry-out. SUB: dst=(A-B) mod 256, carry=borrow (A<B). INC: dst=A+1, carry=1 on 255->0. MOV: dst=A, carry unchanged.
REQ-016 zero=(result==0) for MOV/ADD/SUB/INC/SUM/MAX; CMP: ge=(A>=B unsigned), zero=(A==B), carry unchanged.
REQ-017 SUM/MAX loop over cmd_count registers starting at src_a, addresses wrap mod 32; per element RD_A->CAP_A->EXEC, then WR->DONE.
REQ-018 SUM: 8-bit accumulator from 0, carry sticky-set on any carry-out; MAX: unsigned maximum, carry unchanged.
REQ-019 cmd_count==0 or cmd_op==7: no register access, done and err high together one cycle after handshake, flags unchanged.
REQ-020 Flags update only in EXEC/final loop EXEC and hold otherwise; done and err are one-cycle pulses.
REQ-021 busy high in every non-IDLE state; cmd_valid outside IDLE ignored (no queuing).

Reset
REQ-022 rst asserted: state IDLE immediately; rf_read_en, rf_write_en, rf_address, rf_data_in, busy, done, err, all flags = 0; cmd_ready = 1 after release.
REQ-023 rst mid-operation aborts the command; no partial write issued after reset assertion.

Structure
REQ-024 Package reg_op_pkg: DATA_W, ADDR_W constants, opcode enum, FSM state enum.
REQ-025 Sub-module alu8: combinational ADD/SUB/INC/CMP/MAX-compare with carry/zero/ge outputs; sequencer owns all state.

Verification
REQ-026 R4=141, R6=208; ADD src_a=4 src_b=6 dst=10 -> R10=93, carry=1, zero=0, done at cycle 7.
REQ-027 R6=208, R8=32; SUB 6,8 ->11 -> R11=176, carry=0; SUB 8,4 ->12 -> R12=147, carry=1; INC 12->12 -> R12=148.
REQ-028 CMP 4,6 -> ge=0, no rf_write_en; SUB 4,4 ->13 -> R13=0, zero=1.
REQ-029 R4..R9 = 141,141,208,208,32,32; SUM src_a=4 count=6 dst=13 -> R13=250, carry=1; MAX same range -> R13=208.
REQ-030 rst pulsed in CAP_B of ADD -> no write to dst, outputs zero, next command completes normally; op=7 -> done+err, no bus activity.
